// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle between the L2 cache (line side) and physical memory (burst side)
// for the cacheline burst adaptor.
interface cacheline_burst_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  // Handshake: read_i/write_i are level requests held until resp_o pulses for
  // one cycle. read_o/write_o stay high for the whole burst; each cycle with
  // resp_i high moves exactly one beat, and gaps in resp_i simply stall.
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits one L2 line read/write into a BEATS-long burst on the memory bus and
// reassembles returning read beats into a line. One transaction at a time.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_burst_adaptor_if.slave bus,
  output logic [1:0]              dbg_state
);
  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       beat_cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic [BURST_WIDTH-1:0] beat_buf [BEATS];
  logic [BURST_WIDTH-1:0] line_beats [BEATS];
  logic [LINE_WIDTH-1:0]  assembled;

  assign dbg_state = state;
  assign next_cnt  = beat_cnt + 1'b1;

  // The final read beat is merged combinationally so line_o is valid in DONE.
  always_comb begin
    assembled = '0;
    for (int b = 0; b < BEATS; b++) begin
      line_beats[b] = bus.line_i[b*BURST_WIDTH +: BURST_WIDTH];
      assembled[b*BURST_WIDTH +: BURST_WIDTH] =
        (CNT_W'(b) == beat_cnt) ? bus.burst_i : beat_buf[b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      bus.line_o    <= '0;
      bus.resp_o    <= 1'b0;
      bus.burst_o   <= '0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      for (int b = 0; b < BEATS; b++) beat_buf[b] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            bus.address_o <= {bus.address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            beat_cnt      <= '0;
          end
          // Write has priority when both requests are raised together.
          if (bus.write_i) begin
            state       <= WRITE;
            bus.write_o <= 1'b1;
            bus.burst_o <= line_beats[0];
            for (int b = 0; b < BEATS; b++) beat_buf[b] <= line_beats[b];
          end else if (bus.read_i) begin
            state      <= READ;
            bus.read_o <= 1'b1;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            beat_buf[beat_cnt] <= bus.burst_i;
            beat_cnt           <= next_cnt;
            if (beat_cnt == LAST_BEAT) begin
              state      <= DONE;
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
              bus.line_o <= assembled;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            beat_cnt <= next_cnt;
            if (beat_cnt == LAST_BEAT) begin
              state       <= DONE;
              bus.write_o <= 1'b0;
              bus.burst_o <= '0;
              bus.resp_o  <= 1'b1;
            end else begin
              bus.burst_o <= beat_buf[next_cnt];
            end
          end
        end
        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
